// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory line port between the I-cache and D-cache.
// Fixed D priority with an I-starvation guard; MEM_PORT_ARBITER_TIMEOUT_EN enables a sticky BUSY timeout.
module mem_port_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  // Handshake: a cache holds req (with stable address/data) until it sees its
  // one-cycle ready pulse and drops req by the edge ending that cycle. On the
  // memory side the strobe stays high with stable address/data until mem_ready
  // is sampled high; mem_rdata is valid in that same cycle.

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_e;

  state_e              state_q,   state_d;
  logic [STREAK_W-1:0] streak_q,  streak_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic                wen_q,     wen_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                err_q,     err_d;
  logic                d_wins;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic tmo_unused;
  assign tmo_unused = ^(8'(TIMEOUT));
`endif

  // D wins unless I is also waiting and D has used up its streak allowance.
  assign d_wins = d_req && (!i_req || (streak_q < STREAK_W'(MAX_D_STREAK)));

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = wen_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d     = err_q;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d  = BUSY_D;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          wen_d    = d_wen;
          streak_d = i_req ? (streak_q + 1'b1) : '0;
        end else if (i_req) begin
          state_d  = BUSY_I;
          addr_d   = i_addr;
          wen_d    = 1'b0;
          streak_d = '0;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d   = DONE_I;
          i_rdata_d = mem_rdata;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (tmo_cnt_d == 8'(TIMEOUT)) begin
            state_d   = DONE_I;
            i_rdata_d = '0;
            err_d     = 1'b1;
            tmo_cnt_d = '0;
          end
`endif
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d = DONE_D;
          if (!wen_q) d_rdata_d = mem_rdata;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (tmo_cnt_d == 8'(TIMEOUT)) begin
            state_d = DONE_D;
            if (!wen_q) d_rdata_d = '0;
            err_d     = 1'b1;
            tmo_cnt_d = '0;
          end
`endif
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  // Strobes decode straight from the state flop so an async reset drops them at once.
  assign mem_read  = (state_q == BUSY_I) || ((state_q == BUSY_D) && !wen_q);
  assign mem_write = (state_q == BUSY_D) && wen_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ready   = (state_q == DONE_I);
  assign d_ready   = (state_q == DONE_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

endmodule
